// File: rtl/exc_pkg.sv
// Shared constants, status codes and FSM state for the X/M exception stage.
// Optional cause log is enabled by defining EXC_CAUSE_LOG_EN.
package exc_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_LSB  = 22;
  localparam int AOP_MSB = 6;
  localparam int AOP_LSB = 2;

  localparam logic [4:0] ALU_OP = 5'd0;
  localparam logic [4:0] ADD    = 5'd0;
  localparam logic [4:0] MUL    = 5'd6;
  localparam logic [4:0] DIV    = 5'd7;

  localparam int STATUS_REG_DEF = 30;
  localparam int CODE_ADD_DEF   = 1;
  localparam int CODE_ADDI_DEF  = 2;
  localparam int CODE_SUB_DEF   = 3;
  localparam int CODE_MUL_DEF   = 4;
  localparam int CODE_DIV_DEF   = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic is_md_op(
    input logic [4:0] opc,
    input logic [4:0] aop
  );
    return (opc == ALU_OP) &&
           ((aop == MUL) || (aop == DIV));
  endfunction

endpackage

// File: rtl/exc_pipe_unit_rewrite.sv
// Rewrites an excepting instruction to target the status register.
// Destination r0 always produces a zero result.
module exc_rewrite
  import exc_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int STATUS_REG = STATUS_REG_DEF
) (
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] result,
  input  logic              exc,
  input  logic [7:0]        code,
  output logic [DATA_W-1:0] new_ir,
  output logic [DATA_W-1:0] new_result
);

  logic rd_zero;

  assign rd_zero = (ir[RD_LSB +: REG_W] == '0);

  always_comb begin
    new_ir     = ir;
    new_result = result;
    if (exc) begin
      new_ir[RD_LSB +: REG_W] = REG_W'(STATUS_REG);
      new_result = DATA_W'(code);
    end
    if (rd_zero) begin
      new_result = '0;
    end
  end

endmodule

// File: rtl/exc_pipe_unit.sv
// X/M latch with overflow rewrite and mult/div sequencing.
// Define EXC_CAUSE_LOG_EN to add the sticky cause mask and exception count.
module exc_pipe_unit
  import exc_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int STATUS_REG = STATUS_REG_DEF,
  parameter int CODE_ADD   = CODE_ADD_DEF,
  parameter int CODE_ADDI  = CODE_ADDI_DEF,
  parameter int CODE_SUB   = CODE_SUB_DEF,
  parameter int CODE_MUL   = CODE_MUL_DEF,
  parameter int CODE_DIV   = CODE_DIV_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] dx_ir,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_ovf,
  input  logic              flush,
  output logic              md_start,
  output logic              md_op,
  output logic              md_cancel,
  input  logic              md_ready,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exc,
  output logic              stall_req,
  output logic [DATA_W-1:0] xm_ir,
  output logic [DATA_W-1:0] xm_o
`ifdef EXC_CAUSE_LOG_EN
  ,
  input  logic              cause_clr,
  output logic [7:0]        cause,
  output logic [15:0]       exc_count
`endif
);

  localparam logic [7:0] C_ADD  = 8'(CODE_ADD);
  localparam logic [7:0] C_ADDI = 8'(CODE_ADDI);
  localparam logic [7:0] C_SUB  = 8'(CODE_SUB);
  localparam logic [7:0] C_MUL  = 8'(CODE_MUL);
  localparam logic [7:0] C_DIV  = 8'(CODE_DIV);

  state_t state;
  state_t state_nx;

  logic [DATA_W-1:0] md_ir;
  logic [DATA_W-1:0] ir_nx;
  logic [DATA_W-1:0] o_nx;
  logic [DATA_W-1:0] alu_ir;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] mdw_ir;
  logic [DATA_W-1:0] mdw_res;
  logic [4:0]        opc;
  logic [4:0]        aop;
  logic [7:0]        alu_code;
  logic [7:0]        md_code;
  logic [7:0]        log_code;
  logic              is_md;
  logic              cap;
  logic              log_evt;
  logic              start_c;
  logic              op_c;
  logic              cancel_c;
  logic              stall_c;

  assign opc   = dx_ir[OPC_MSB:OPC_LSB];
  assign aop   = dx_ir[AOP_MSB:AOP_LSB];
  assign is_md = is_md_op(opc, aop);

  always_comb begin
    alu_code = C_SUB;
    unique case (1'b1)
      (opc != ALU_OP):
        alu_code = C_ADDI;
      (opc == ALU_OP) && (aop == ADD):
        alu_code = C_ADD;
      (opc == ALU_OP) && (aop != ADD):
        alu_code = C_SUB;
      default:
        alu_code = C_SUB;
    endcase
  end

  assign md_code = md_ir[AOP_LSB] ? C_DIV : C_MUL;

  exc_rewrite #(
    .DATA_W     (DATA_W),
    .REG_W      (REG_W),
    .STATUS_REG (STATUS_REG)
  ) u_alu_rw (
    .ir         (dx_ir),
    .result     (alu_out),
    .exc        (alu_ovf),
    .code       (alu_code),
    .new_ir     (alu_ir),
    .new_result (alu_res)
  );

  exc_rewrite #(
    .DATA_W     (DATA_W),
    .REG_W      (REG_W),
    .STATUS_REG (STATUS_REG)
  ) u_md_rw (
    .ir         (md_ir),
    .result     (md_result),
    .exc        (md_exc),
    .code       (md_code),
    .new_ir     (mdw_ir),
    .new_result (mdw_res)
  );

  always_comb begin
    state_nx = state;
    start_c  = 1'b0;
    op_c     = 1'b0;
    cancel_c = 1'b0;
    stall_c  = 1'b0;
    cap      = 1'b0;
    ir_nx    = '0;
    o_nx     = '0;
    log_evt  = 1'b0;
    log_code = alu_code;
    if (flush) begin
      if (state == BUSY) begin
        cancel_c = 1'b1;
        state_nx = IDLE;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (is_md) begin
            start_c  = 1'b1;
            op_c     = aop[0];
            stall_c  = 1'b1;
            cap      = 1'b1;
            state_nx = BUSY;
          end else begin
            ir_nx   = alu_ir;
            o_nx    = alu_res;
            log_evt = alu_ovf;
          end
        end
        BUSY: begin
          if (md_ready) begin
            state_nx = IDLE;
            ir_nx    = mdw_ir;
            o_nx     = mdw_res;
            log_evt  = md_exc;
            log_code = md_code;
          end else begin
            stall_c = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign md_start  = reset_n & start_c;
  assign md_op     = reset_n & op_c;
  assign md_cancel = reset_n & cancel_c;
  assign stall_req = reset_n & stall_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      xm_ir <= '0;
      xm_o  <= '0;
      md_ir <= '0;
    end else begin
      state <= state_nx;
      xm_ir <= ir_nx;
      xm_o  <= o_nx;
      if (cap) begin
        md_ir <= dx_ir;
      end
    end
  end

`ifdef EXC_CAUSE_LOG_EN
  logic [7:0] hot;

  assign hot = 8'd1 << log_code[2:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cause     <= '0;
      exc_count <= '0;
    end else if (log_evt) begin
      if (cause_clr) begin
        cause     <= hot;
        exc_count <= 16'd1;
      end else begin
        cause <= cause | hot;
        if (exc_count != 16'hffff) begin
          exc_count <= exc_count + 16'd1;
        end
      end
    end else if (cause_clr) begin
      cause     <= '0;
      exc_count <= '0;
    end
  end
`else
  logic unused_log;

  assign unused_log = ^{log_evt, log_code};
`endif

endmodule

// File: tb/tb_exc_pipe_unit.sv
// Scoreboard bench for exc_pipe_unit: driver queues expectations,
// monitor pops and compares each cycle.
module tb_exc_pipe_unit;

  typedef struct {
    int          id;
    logic [31:0] ir;
    logic [31:0] o;
    logic        st;
    logic        sta;
    logic        op;
    logic        can;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] dx_ir = '0;
  logic [31:0] alu_out = '0;
  logic        alu_ovf = 1'b0;
  logic        flush = 1'b0;
  logic        md_start;
  logic        md_op;
  logic        md_cancel;
  logic        md_ready = 1'b0;
  logic [31:0] md_result = '0;
  logic        md_exc = 1'b0;
  logic        stall_req;
  logic [31:0] xm_ir;
  logic [31:0] xm_o;
`ifdef EXC_CAUSE_LOG_EN
  logic        cause_clr = 1'b0;
  logic [7:0]  cause;
  logic [15:0] exc_count;
`endif

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_sent = 0;
  int   n_done = 0;

  always #5 clock = ~clock;

  exc_pipe_unit dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .dx_ir     (dx_ir),
    .alu_out   (alu_out),
    .alu_ovf   (alu_ovf),
    .flush     (flush),
    .md_start  (md_start),
    .md_op     (md_op),
    .md_cancel (md_cancel),
    .md_ready  (md_ready),
    .md_result (md_result),
    .md_exc    (md_exc),
    .stall_req (stall_req),
    .xm_ir     (xm_ir),
    .xm_o      (xm_o)
`ifdef EXC_CAUSE_LOG_EN
    ,
    .cause_clr (cause_clr),
    .cause     (cause),
    .exc_count (exc_count)
`endif
  );

  function automatic logic [31:0] mk(
    input logic [4:0] opc,
    input logic [4:0] rd,
    input logic [4:0] aop
  );
    return {opc, rd, 15'h0, aop, 2'b00};
  endfunction

  task automatic chk(
    input string       nm,
    input int          id,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %h expected %h",
               nm, id, act, exp);
    end
  endtask

  task automatic drive(
    input logic [31:0] ir,
    input logic [31:0] aout,
    input logic        ovf,
    input logic        fl,
    input logic        rdy,
    input logic [31:0] res,
    input logic        mexc,
    input logic [31:0] eir,
    input logic [31:0] eo,
    input logic        est,
    input logic        esta,
    input logic        eop,
    input logic        ecan
  );
    exp_t e;
    @(posedge clock);
    #2;
    dx_ir     = ir;
    alu_out   = aout;
    alu_ovf   = ovf;
    flush     = fl;
    md_ready  = rdy;
    md_result = res;
    md_exc    = mexc;
    e.id  = n_sent;
    e.ir  = eir;
    e.o   = eo;
    e.st  = est;
    e.sta = esta;
    e.op  = eop;
    e.can = ecan;
    q.push_back(e);
    n_sent++;
  endtask

  task automatic drain();
    int k = 0;
    while (n_done != n_sent && k < 40) begin
      @(posedge clock);
      #2;
      k++;
    end
    if (n_done != n_sent) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: done %0d sent %0d", n_done, n_sent);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_req", e.id, 32'(stall_req), 32'(e.st));
        chk("md_start", e.id, 32'(md_start), 32'(e.sta));
        chk("md_op", e.id, 32'(md_op), 32'(e.op));
        chk("md_cancel", e.id, 32'(md_cancel), 32'(e.can));
        @(posedge clock);
        #1;
        chk("xm_ir", e.id, xm_ir, e.ir);
        chk("xm_o", e.id, xm_o, e.o);
        n_done++;
      end
    end
  end

  initial begin : stim
    #3;
    chk("rst xm_ir", -1, xm_ir, 32'h0);
    chk("rst xm_o", -1, xm_o, 32'h0);
    chk("rst stall", -1, 32'(stall_req), 32'h0);
    chk("rst start", -1, 32'(md_start), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // overflow rewrites: add, sub, addi
    drive(mk(0, 3, 0), 32'h55, 1, 0, 0, 0, 0,
          mk(0, 30, 0), 32'd1, 0, 0, 0, 0);
    drive(mk(0, 3, 1), 32'h55, 1, 0, 0, 0, 0,
          mk(0, 30, 1), 32'd3, 0, 0, 0, 0);
    drive(mk(5, 3, 0), 32'h55, 1, 0, 0, 0, 0,
          mk(5, 30, 0), 32'd2, 0, 0, 0, 0);
    // r0 destination zeroes result
    drive(mk(0, 0, 0), 32'h1234, 0, 0, 0, 0, 0,
          mk(0, 0, 0), 32'd0, 0, 0, 0, 0);
    drive(mk(0, 4, 0), 32'habcd, 0, 0, 0, 0, 0,
          mk(0, 4, 0), 32'habcd, 0, 0, 0, 0);

    // mul r5, ready four cycles after launch
    drive(mk(0, 5, 6), 0, 0, 0, 0, 0, 0,
          32'h0, 32'h0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(mk(0, 5, 6), 0, 0, 0, 0, 0, 0,
            32'h0, 32'h0, 1, 0, 0, 0);
    end
    drive(mk(0, 5, 6), 0, 0, 0, 1, 32'd42, 0,
          mk(0, 5, 6), 32'd42, 0, 0, 0, 0);
    drive(mk(0, 0, 0), 32'h5, 0, 0, 0, 0, 0,
          mk(0, 0, 0), 32'h0, 0, 0, 0, 0);

    // div r7 with divide exception
    drive(mk(0, 7, 7), 0, 0, 0, 0, 0, 0,
          32'h0, 32'h0, 1, 1, 1, 0);
    drive(mk(0, 7, 7), 0, 0, 0, 1, 32'd99, 1,
          mk(0, 30, 7), 32'd5, 0, 0, 0, 0);

    // md_ready in IDLE is ignored
    drive(mk(0, 2, 0), 32'd9, 0, 0, 1, 32'd77, 0,
          mk(0, 2, 0), 32'd9, 0, 0, 0, 0);

    // flush suppresses launch in IDLE
    drive(mk(0, 6, 6), 0, 0, 1, 0, 0, 0,
          32'h0, 32'h0, 0, 0, 0, 0);
    drive(mk(0, 1, 0), 32'h10, 0, 0, 0, 0, 0,
          mk(0, 1, 0), 32'h10, 0, 0, 0, 0);

    // flush in BUSY with coincident md_ready
    drive(mk(0, 5, 6), 0, 0, 0, 0, 0, 0,
          32'h0, 32'h0, 1, 1, 0, 0);
    drive(mk(0, 5, 6), 0, 0, 1, 1, 32'd9, 0,
          32'h0, 32'h0, 0, 0, 0, 1);
    drive(mk(0, 8, 0), 32'h22, 0, 0, 0, 0, 0,
          mk(0, 8, 0), 32'h22, 0, 0, 0, 0);

    // flush kills a plain ALU result
    drive(mk(0, 9, 0), 32'h33, 1, 1, 0, 0, 0,
          32'h0, 32'h0, 0, 0, 0, 0);

    // mul r0 with exception: rd rewritten, result zero
    drive(mk(0, 0, 6), 0, 0, 0, 0, 0, 0,
          32'h0, 32'h0, 1, 1, 0, 0);
    drive(mk(0, 0, 6), 0, 0, 0, 1, 32'd7, 1,
          mk(0, 30, 6), 32'd0, 0, 0, 0, 0);

    // asynchronous reset mid-BUSY
    drive(mk(0, 5, 6), 0, 0, 0, 0, 0, 0,
          32'h0, 32'h0, 1, 1, 0, 0);
    drive(mk(0, 12, 0), 32'h44, 0, 0, 0, 0, 0,
          32'h0, 32'h0, 1, 0, 0, 0);
    drain();
    reset_n = 1'b0;
    #1;
    chk("arst xm_ir", -2, xm_ir, 32'h0);
    chk("arst xm_o", -2, xm_o, 32'h0);
    chk("arst stall", -2, 32'(stall_req), 32'h0);
    chk("arst start", -2, 32'(md_start), 32'h0);
    chk("arst cancel", -2, 32'(md_cancel), 32'h0);
    dx_ir = '0;
    @(negedge clock);
    reset_n = 1'b1;
    drive(mk(0, 11, 0), 32'h77, 0, 0, 0, 0, 0,
          mk(0, 11, 0), 32'h77, 0, 0, 0, 0);
    drain();

`ifdef EXC_CAUSE_LOG_EN
    drive(mk(0, 3, 0), 32'h1, 1, 0, 0, 0, 0,
          mk(0, 30, 0), 32'd1, 0, 0, 0, 0);
    drive(mk(0, 4, 0), 32'h1, 1, 0, 0, 0, 0,
          mk(0, 30, 0), 32'd1, 0, 0, 0, 0);
    drain();
    chk("exc_count", -3, 32'(exc_count), 32'd2);
    chk("cause", -3, 32'(cause), 32'h02);
    cause_clr = 1'b1;
    drive(mk(0, 4, 0), 32'h6, 0, 0, 0, 0, 0,
          mk(0, 4, 0), 32'h6, 0, 0, 0, 0);
    drain();
    cause_clr = 1'b0;
    chk("clr count", -4, 32'(exc_count), 32'd0);
    chk("clr cause", -4, 32'(cause), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

endmodule
